// File: rtl/cpu_datapath.sv
// Register and datapath stage of the 8-bit CPU: FSM state, PC, IR, A, B, R, zero flag and memory port.
// Optional retired-instruction counter enabled by defining CPU_INSTR_COUNT_EN.
module cpu_datapath #(
   parameter logic [7:0]  RESET_PC    = 8'h00,
   parameter int unsigned INSTR_CNT_W = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] next_state,
   input  logic       pc_we,
   input  logic       pc_sel,
   input  logic       pc_jmp_sel,
   input  logic [3:0] pc_offset,
   input  logic       addr_sel,
   input  logic [3:0] addr_offset,
   input  logic       mem_sel,
   input  logic       mem_we,
   input  logic [2:0] alu_opcode,
   input  logic       alu_sel_a,
   input  logic       alu_sel_b,
   input  logic       alu_we,
   input  logic       zf_we,
   input  logic       ir_we,
   input  logic       a_sel,
   input  logic       a_we,
   input  logic       b_sel,
   input  logic       b_we,
   input  logic       halt,
   input  logic [7:0] mem_rdata,
   output logic [2:0] state,
   output logic [7:0] instr,
   output logic       zf,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       mem_we_o,
   output logic       halted,
   output logic [7:0] pc
`ifdef CPU_INSTR_COUNT_EN
   ,
   output logic [INSTR_CNT_W-1:0] instr_count
`endif
);

   localparam int unsigned DW = 8;
   localparam int unsigned OW = 4;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'b000,
      ST_DECODE = 3'b001,
      ST_HALT   = 3'b101,
      ST_RSVD   = 3'b111
   } state_e;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_AND = 3'b001,
      OP_NOT = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100
   } alu_op_e;

   state_e        state_q, state_d;
   logic [DW-1:0] pc_q, pc_d;
   logic [DW-1:0] ir_q, ir_d;
   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic [DW-1:0] r_q, r_d;
   logic          zf_q, zf_d;
   logic          halted_q, halted_d;

   logic [DW-1:0] alu_x, alu_y, alu_res;
   logic [DW-1:0] jmp_base, jmp_target;

   // ALU operand select and combinational result
   always_comb begin
      alu_x = alu_sel_a ? b_q : a_q;
      alu_y = alu_sel_b ? b_q : a_q;
      case (alu_op_e'(alu_opcode))
         OP_ADD:  alu_res = DW'(alu_x + alu_y);
         OP_AND:  alu_res = alu_x & alu_y;
         OP_NOT:  alu_res = ~alu_x;
         OP_OR:   alu_res = alu_x | alu_y;
         OP_XOR:  alu_res = alu_x ^ alu_y;
         default: alu_res = alu_x;
      endcase
   end

   assign jmp_base   = pc_jmp_sel ? b_q : a_q;
   assign jmp_target = DW'(jmp_base + {{(DW-OW){1'b0}}, pc_offset});

   // Next-state logic; a halt request wins over every write in its cycle
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      r_d      = r_q;
      zf_d     = zf_q;
      halted_d = halted_q;
      if (!halted_q) begin
         if (halt) begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
         end else begin
            state_d = (next_state == ST_RSVD) ? ST_FETCH : state_e'(next_state);
            if (alu_we) r_d = alu_res;
            if (zf_we)  zf_d = (alu_res == '0);
            if (pc_we)  pc_d = pc_sel ? jmp_target : DW'(pc_q + DW'(1));
            if (ir_we)  ir_d = mem_rdata;
            if (a_we)   a_d = a_sel ? mem_rdata : r_q;
            if (b_we)   b_d = b_sel ? mem_rdata : r_q;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_FETCH;
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         r_q      <= '0;
         zf_q     <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         r_q      <= r_d;
         zf_q     <= zf_d;
         halted_q <= halted_d;
      end
   end

   assign state  = state_q;
   assign instr  = ir_q;
   assign zf     = zf_q;
   assign halted = halted_q;
   assign pc     = pc_q;

   // Memory port is combinational so the async read sees this cycle's address
   assign mem_addr  = addr_sel ? DW'(b_q + {{(DW-OW){1'b0}}, addr_offset}) : pc_q;
   assign mem_wdata = mem_sel ? b_q : a_q;
   assign mem_we_o  = mem_we & ~halted_q;

`ifdef CPU_INSTR_COUNT_EN
   logic [INSTR_CNT_W-1:0] cnt_q, cnt_d;

   // Saturating count of edges spent in DECODE while running
   always_comb begin
      cnt_d = cnt_q;
      if ((state_q == ST_DECODE) && !halted_q && (cnt_q != '1))
         cnt_d = cnt_q + INSTR_CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign instr_count = cnt_q;
`else
   logic unused_cnt_w;
   assign unused_cnt_w = (INSTR_CNT_W != 0);
`endif

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
Register-and-datapath stage of the 8-bit CPU. It sits directly downstream of control_unit, consuming every control strobe that control_unit produces, and feeds back `instr`, `state` and `zf`. The block holds the FSM state register, PC, IR, registers A and B, the ALU result register R and the zero flag. It also drives the external memory port. Memory read is asynchronous (combinational `mem_rdata`) and memory write is synchronous on `clk`.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset.
INSTR_CNT_W, 16, width of the retired-instruction counter (used only with the optional feature).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
next_state  input  3  next FSM state from control_unit
pc_we  input  1  PC load enable
pc_sel  input  1  0: PC+1; 1: jump target
pc_jmp_sel  input  1  jump base: 0 = A, 1 = B
pc_offset  input  4  jump offset, zero-extended
addr_sel  input  1  mem_addr source: 0 = PC; 1 = B + addr_offset
addr_offset  input  4  address offset, zero-extended
mem_sel  input  1  mem_wdata source: 0 = A, 1 = B
mem_we  input  1  memory write request
alu_opcode  input  3  ALU operation
alu_sel_a  input  1  ALU operand X: 0 = A, 1 = B
alu_sel_b  input  1  ALU operand Y: 0 = A, 1 = B
alu_we  input  1  R load enable
zf_we  input  1  zero-flag load enable
ir_we  input  1  IR <= mem_rdata
a_sel  input  1  A source: 0 = R, 1 = mem_rdata
a_we  input  1  A load enable
b_sel  input  1  B source: 0 = R, 1 = mem_rdata
b_we  input  1  B load enable
halt  input  1  halt request
mem_rdata  input  8  memory read data (combinational)
state  output  3  current FSM state, to control_unit
instr  output  8  IR contents, to control_unit
zf  output  1  zero flag, to control_unit
mem_addr  output  8  memory address (combinational)
mem_wdata  output  8  memory write data (combinational)
mem_we_o  output  1  gated memory write enable
halted  output  1  sticky halt indicator
pc  output  8  current PC (debug)

Behaviour:
- Reset (asynchronous) loads:
  - state = 3'b000 (FETCH), pc = RESET_PC.
  - IR, A, B, R = 8'h00.
  - zf = 0, halted = 0.
  - Reset asserted mid-instruction discards all in-flight work; the first edge after release starts a FETCH.
- State register: every rising edge loads `next_state` while halted = 0. A `next_state` of 3'b111 loads FETCH (3'b000).
- ALU is combinational on operands X and Y:
  - 000 ADD: X+Y mod 256.
  - 001 AND: X&Y.
  - 010 NOT: ~X.
  - 011 OR: X|Y.
  - 100 XOR: X^Y.
  - 101-111: pass X.
- On a rising edge:
  - alu_we = 1: R <= result.
  - zf_we = 1: zf <= (result == 8'h00). Loading zf does not require alu_we.
- PC update when pc_we = 1:
  - pc_sel = 0: pc <= pc+1, wrapping 8'hFF -> 8'h00.
  - pc_sel = 1: pc <= (pc_jmp_sel ? B : A) + {4'b0, pc_offset} mod 256.
- mem_addr = addr_sel ? (B + {4'b0, addr_offset}) mod 256 : pc.
- mem_wdata = mem_sel ? B : A.
- mem_we_o = mem_we & ~halted.
- ir_we = 1: IR <= mem_rdata.
- a_we = 1: A <= (a_sel ? mem_rdata : R). b_we = 1: B <= (b_sel ? mem_rdata : R).
- Every source is sampled at its pre-edge value:
  - R written and read by a_we in the same cycle gives A the old R.
  - A jump using A, with a_we in the same cycle, targets the old A.
- Enables in the same cycle are independent; all of them may be asserted together.
- halt = 1 at an edge while not halted:
  - halted <= 1 and state <= 3'b101 (HALT_STATE).
  - All register writes requested in that cycle are suppressed.
- While halted = 1:
  - All register, PC, IR, zf and state updates are blocked.
  - mem_we_o is held at 0.
  - Only reset clears halted.

Optional Feature:
Macro: CPU_INSTR_COUNT_EN.
- Defined: adds output `instr_count` [INSTR_CNT_W-1:0].
  - Reset value 0.
  - Increments on each edge where state = 3'b001 (DECODE) and halted = 0.
  - Saturates at all-ones; it does not wrap.
- Undefined: port and counter are absent; all other behaviour is unchanged.

Test Plan:
- Reset with RESET_PC = 8'h00: assert reset mid-cycle -> immediately state=000, pc=00, instr=00, zf=0, halted=0, mem_addr=00.
- Fetch: addr_sel=0, mem_rdata=8'h14, ir_we=1, pc_we=1, pc_sel=0 at pc=8'hFF -> instr=14, pc=00 (wrap), state follows next_state.
- ALU/zf: A=8'h80, B=8'h80, alu_opcode=000, alu_we=1, zf_we=1 -> R=00, zf=1. Then a_sel=0, a_we=1 -> A=00. Then NOT with alu_sel_a=1 -> result 8'h7F, zf=0.
- Jumps: A=8'hF5, pc_sel=1, pc_jmp_sel=0, pc_offset=4'hF, pc_we=1 -> pc=8'h04. With B=8'h10, pc_jmp_sel=1, offset 3 -> pc=8'h13.
- Memory: B=8'h20, addr_sel=1, addr_offset=4'h5, mem_sel=0, A=8'h3C, mem_we=1 -> mem_addr=25, mem_wdata=3C, mem_we_o=1. Load path: b_sel=1, b_we=1, mem_rdata=8'h99 -> B=99.
- Halt: halt=1 with a_we=1 -> A unchanged, state=101, halted=1. Subsequent mem_we=1 -> mem_we_o=0, pc frozen. Reset -> halted=0.
